// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag and state types
// for the handshaked sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NEG = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8,
    OP_SRA = 4'd9,
    OP_SLA = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(
    alu_op_e op
  );
    return (op == OP_SLL) ||
           (op == OP_SRL) ||
           (op == OP_SRA) ||
           (op == OP_SLA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand beat in, result beat out,
// each with its own valid/ready pair.
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   F;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;
  logic             err;

  modport master (
    output in_valid,
    output A,
    output B,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  F,
    input  C,
    input  V,
    input  Z,
    input  N,
    input  err
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output F,
    output C,
    output V,
    output Z,
    output N,
    output err
  );

endinterface

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ops and their flags.
// Shift opcodes yield zero here; the top runs them.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH:0]   f,
  output alu_flags_t       flags,
  output logic             err
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] neg;
  logic             c;
  logic             v;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign neg = '0 - a;

  always_comb begin
    f   = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        f = sum;
        c = sum[WIDTH];
        v = (a[M] == b[M]) &&
            (sum[M] != a[M]);
      end
      (op == OP_SUB): begin
        f = dif;
        c = dif[WIDTH];
        v = (a[M] != b[M]) &&
            (dif[M] != a[M]);
      end
      (op == OP_NEG): begin
        f = {1'b0, neg};
        v = a[M] && ~|a[M-1:0];
      end
      (op == OP_OR):  f = {1'b0, a | b};
      (op == OP_AND): f = {1'b0, a & b};
      (op == OP_XOR): f = {1'b0, a ^ b};
      (op == OP_NOT): f = {1'b0, ~b};
      is_shift(op): ;
      default: err = 1'b1;
    endcase
  end

  assign flags.c = c;
  assign flags.v = v;
  assign flags.z = ~|f[M:0];
  assign flags.n = f[M];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result,
// flags, and bit-serial shifts under a 3-state FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int M = WIDTH - 1;

  alu_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] sh;
  logic             sh_c;
  logic             sh_v;
  logic [SHW-1:0]   cnt;
  logic [WIDTH:0]   f_q;
  alu_flags_t       fl_q;
  logic             err_q;

  alu_op_e          in_op;
  logic [SHW-1:0]   in_n;
  logic             in_ready;
  logic             accept;

  logic [WIDTH:0]   core_f;
  alu_flags_t       core_fl;
  logic             core_err;

  logic [WIDTH:0]   ld_f;
  alu_flags_t       ld_fl;
  logic             ld_err;
  logic             ld_shift;

  logic [WIDTH-1:0] step_d;
  logic             step_c;
  logic             step_v;

  assign in_op = alu_op_e'(bus.sel);
  assign in_n  = bus.B[SHW-1:0];

  assign in_ready = !rst && (
    (state == ST_IDLE) ||
    ((state == ST_DONE) && bus.out_ready));
  assign accept = bus.in_valid && in_ready;

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (bus.A),
    .b     (bus.B),
    .op    (in_op),
    .f     (core_f),
    .flags (core_fl),
    .err   (core_err)
  );

  // A shift by zero completes like a single-cycle op.
  always_comb begin
    ld_f     = core_f;
    ld_fl    = core_fl;
    ld_err   = core_err;
    ld_shift = 1'b0;
    if (is_shift(in_op)) begin
      if (in_n == '0) begin
        ld_f  = {1'b0, bus.A};
        ld_fl = '{c: 1'b0,
                  v: 1'b0,
                  z: ~|bus.A,
                  n: bus.A[M]};
      end else begin
        ld_shift = 1'b1;
      end
    end
  end

  // One-bit shift step; SLA flags a sign change.
  always_comb begin
    step_d = sh;
    step_c = 1'b0;
    step_v = 1'b0;
    unique case (1'b1)
      (op_q == OP_SLL): begin
        step_d = {sh[M-1:0], 1'b0};
        step_c = sh[M];
      end
      (op_q == OP_SLA): begin
        step_d = {sh[M-1:0], 1'b0};
        step_c = sh[M];
        step_v = sh[M] ^ sh[M-1];
      end
      (op_q == OP_SRL): begin
        step_d = {1'b0, sh[M:1]};
        step_c = sh[0];
      end
      (op_q == OP_SRA): begin
        step_d = {sh[M], sh[M:1]};
        step_c = sh[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= OP_ADD;
      sh    <= '0;
      sh_c  <= 1'b0;
      sh_v  <= 1'b0;
      cnt   <= '0;
      f_q   <= '0;
      fl_q  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            f_q   <= {1'b0, sh};
            fl_q  <= '{c: sh_c,
                       v: sh_v,
                       z: ~|sh,
                       n: sh[M]};
            err_q <= 1'b0;
          end else begin
            sh   <= step_d;
            sh_c <= step_c;
            sh_v <= sh_v | step_v;
            cnt  <= cnt - SHW'(1);
          end
        end
        default: begin
          if (accept) begin
            if (ld_shift) begin
              state <= ST_SHIFT;
              op_q  <= in_op;
              sh    <= bus.A;
              sh_c  <= 1'b0;
              sh_v  <= 1'b0;
              cnt   <= in_n;
            end else begin
              state <= ST_DONE;
              f_q   <= ld_f;
              fl_q  <= ld_fl;
              err_q <= ld_err;
            end
          end else if (state == ST_DONE &&
                       bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.F         = f_q;
  assign bus.C         = fl_q.c;
  assign bus.V         = fl_q.v;
  assign bus.Z         = fl_q.z;
  assign bus.N         = fl_q.n;
  assign bus.err       = err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU. Generalises the 3-bit combinational ALU to `WIDTH` bits, adds registered results, C/V/Z/N flags and an illegal-opcode flag. Shift ops run iteratively, one bit per cycle, under a small FSM. Sits between an operand producer and a result consumer, with valid/ready on both sides.

## Interface

**Parameters**
- `WIDTH`, default 8: operand width; must be a power of two, ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: width of the shift amount; derived, not overridden.

**Ports**
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: the operand/op beat is valid.
- `in_ready` out 1: the block accepts the beat this cycle.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B; for shifts, `B[SHW-1:0]` is the shift amount.
- `sel` in 4: opcode (`alu_op_e`).
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer takes the result.
- `F` out WIDTH+1: result; `F[WIDTH]` is the carry/borrow extension.
- `C`, `V`, `Z`, `N` out 1 each: carry, signed overflow, zero, negative.
- `err` out 1: the accepted `sel` was illegal.

## Operation

- **Opcodes**
  - 0 ADD: `F = A+B`.
  - 1 SUB: `F = {borrow, A-B}`.
  - 2 NEG: `F = {0, -A}`.
  - 3 OR, 4 AND, 5 XOR.
  - 6 NOT: `~B`.
  - 7 SLL, 8 SRL, 9 SRA, 10 SLA, each by `n = B[SHW-1:0]`.
  - 11–15 are illegal.
  - For all non-ADD/SUB ops, `F[WIDTH] = 0`.
- **Flags** (registered with `F`)
  - `Z`: `F[WIDTH-1:0] == 0`.
  - `N`: `F[WIDTH-1]`.
  - `C`:
    - ADD: carry out.
    - SUB: borrow, i.e. unsigned `A < B`.
    - Shifts: the last bit shifted out; 0 if `n = 0`.
    - All other ops: 0.
  - `V`:
    - ADD/SUB: two's-complement overflow.
    - NEG: set when `A = 100…0`.
    - SLA: sticky; set if the sign bit changed on any step.
    - All other ops: 0.
- **Illegal `sel`**: `F = 0`, `Z = 1`, other flags 0, `err = 1`, single-cycle. `err = 0` for legal ops.
- **Input capture**: `A`, `B` and `sel` are captured at acceptance. Input changes after acceptance have no effect.
- **FSM states**
  - IDLE: no result held.
  - SHIFT: shifting, with a down-counter `cnt`.
  - DONE: result held, `out_valid = 1`.
- **Transitions**
  - An accepted beat with a non-shift op, or a shift with `n = 0`, goes to DONE.
  - An accepted shift with `n > 0` goes to SHIFT with `cnt = n`. Each SHIFT cycle shifts by 1 and decrements `cnt`. When `cnt` reaches 0, go to DONE.
  - DONE with `out_ready = 1` and no new accept goes to IDLE.
  - DONE with `out_ready = 1` and a new accept goes to DONE or SHIFT directly (back-to-back).
- **Handshake rules**
  - `in_ready = !rst && (state == IDLE || (state == DONE && out_ready))`. This is combinational from `out_ready`.
  - `out_valid = (state == DONE)`.
  - While `out_valid && !out_ready`, `F`, the flags and `err` hold stable.
  - `in_ready = 0` throughout SHIFT.

## Timing

- **Reset**: state IDLE, `out_valid = 0`, `in_ready = 0` while `rst` is high. `F = 0`, `C = V = Z = N = 0`, `err = 0`, `cnt = 0`.
- **Latency** (accept at edge k, result visible at):
  - Single-cycle op: edge k+1.
  - Shift by `n`: edge k+1+n.
- **Throughput**: single-cycle ops sustain 1 per clock with `out_ready` held at 1. A shift blocks for n+1 cycles.
- **Reset mid-SHIFT or mid-DONE**: the operation is abandoned and no result is produced. The next cycle after `rst` drops is IDLE with `in_ready = 1`.
- **Reset wins** over a simultaneous accept or consume.
- **Shift amount**: `n` ranges 0..WIDTH-1; there is no wrap beyond WIDTH-1.

## Structure

- Package `alu_pkg` holds:
  - enum `alu_op_e` (4-bit, codes above);
  - struct `alu_flags_t` (C, V, Z, N);
  - state enum `alu_state_e`;
  - function `is_shift(alu_op_e)`.
- Sub-module `alu_comb_core #(WIDTH)`: combinational single-cycle ops and flags (ADD..NOT, illegal). The top holds the FSM, the shift datapath, the counter and the output registers.

## Test plan

All scenarios use `WIDTH = 8`.

- **ADD**: `0xFF + 0x01` → `F = 0x100`, `C = 1`, `Z = 1`, `V = 0`, `N = 0`; `out_valid` at edge k+1.
- **SUB**: `0x80 - 0x01` → `F = 0x07F`, `V = 1`, `C = 0`, `N = 0`. Then `0x01 - 0x02` → `F = 0x1FF`, `C = 1`, `N = 1`.
- **SRA**: `0x90`, `B = 3` → `F = 0x0F2`, `C = 0`; `in_ready = 0` for 4 cycles; `out_valid` at edge k+4.
- **SLA**: `0x40`, `B = 1` → `F = 0x080`, `V = 1`, `C = 0`. SLL `0x81`, `B = 1` → `F = 0x002`, `C = 1`.
- **Back-pressure**:
  - Hold `out_ready = 0` for 5 cycles: `F` and flags stay stable and `in_ready = 0`.
  - Then stream 4 XORs with `out_ready = 1`: 4 results arrive on consecutive cycles, in order.
- **Illegal op and reset**:
  - `sel = 4'hB` → `F = 0`, `Z = 1`, `err = 1`.
  - Assert `rst` during SHIFT: no `out_valid`; all outputs 0; `in_ready = 1` the cycle after `rst` falls.
